// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub
// Brief    : Digit-serial pipelined adder/subtractor with valid/ready flow.
// Revision : 1.0
// ============================================================================
module pipelined_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf
);
    localparam int STAGES = WIDTH / DIGIT;

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    logic [WIDTH-1:0]  w_b_eff;
    logic              w_c_eff;
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] w_vin;
    logic [STAGES:0]   w_open;

    assign w_b_eff = b ^ {WIDTH{sub}};
    assign w_c_eff = cin ^ sub;

    // w_open[k]: stage k may capture this cycle (empty or draining downstream)
    always_comb begin
        w_open[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_open[k] = ~r_valid[k] | w_open[k+1];
        end
    end

    always_comb begin
        w_vin[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_vin[k] = r_valid[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else begin
            r_valid <= (w_open[STAGES-1:0] & w_vin) | (~w_open[STAGES-1:0] & r_valid);
        end
    end

    assign in_ready  = rst & w_open[0];
    assign out_valid = r_valid[STAGES-1];

    // Non-final stages: resolved low sum bits grow, unresolved operand bits shrink.
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_stage
        localparam int LO_BITS = (k + 1) * DIGIT;

        logic [LO_BITS-1:0]             r_sum;
        logic [WIDTH-LO_BITS-1:0]       r_a;
        logic [WIDTH-LO_BITS-1:0]       r_b;
        logic                           r_cy;
        logic [WIDTH-LO_BITS+DIGIT-1:0] w_a_in;
        logic [WIDTH-LO_BITS+DIGIT-1:0] w_b_in;
        logic                           w_c_in;
        logic [LO_BITS-1:0]             w_sum_next;
        logic [DIGIT:0]                 w_dig;

        assign w_dig = {1'b0, w_a_in[DIGIT-1:0]} + {1'b0, w_b_in[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, w_c_in};

        if (k == 0) begin : g_src
            assign w_a_in     = a;
            assign w_b_in     = w_b_eff;
            assign w_c_in     = w_c_eff;
            assign w_sum_next = w_dig[DIGIT-1:0];
        end else begin : g_src
            assign w_a_in     = g_stage[k-1].r_a;
            assign w_b_in     = g_stage[k-1].r_b;
            assign w_c_in     = g_stage[k-1].r_cy;
            assign w_sum_next = {w_dig[DIGIT-1:0], g_stage[k-1].r_sum};
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_sum <= '0;
                r_a   <= '0;
                r_b   <= '0;
                r_cy  <= 1'b0;
            end else if (w_open[k] && w_vin[k]) begin
                r_sum <= w_sum_next;
                r_a   <= w_a_in[WIDTH-LO_BITS+DIGIT-1:DIGIT];
                r_b   <= w_b_in[WIDTH-LO_BITS+DIGIT-1:DIGIT];
                r_cy  <= w_dig[DIGIT];
            end
        end
    end

    logic [DIGIT-1:0] w_a_last;
    logic [DIGIT-1:0] w_b_last;
    logic             w_c_last;
    logic [DIGIT:0]   w_dig_last;
    logic [WIDTH-1:0] w_s_next;
    logic             w_ovf_next;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_ovf;

    if (STAGES == 1) begin : g_last_src
        assign w_a_last = a;
        assign w_b_last = w_b_eff;
        assign w_c_last = w_c_eff;
        assign w_s_next = w_dig_last[DIGIT-1:0];
    end else begin : g_last_src
        assign w_a_last = g_stage[STAGES-2].r_a;
        assign w_b_last = g_stage[STAGES-2].r_b;
        assign w_c_last = g_stage[STAGES-2].r_cy;
        assign w_s_next = {w_dig_last[DIGIT-1:0], g_stage[STAGES-2].r_sum};
    end

    assign w_dig_last = {1'b0, w_a_last} + {1'b0, w_b_last} + {{DIGIT{1'b0}}, w_c_last};
    // Carry into the MSB is recovered as a ^ b ^ sum at that bit position.
    assign w_ovf_next = w_a_last[DIGIT-1] ^ w_b_last[DIGIT-1]
                      ^ w_dig_last[DIGIT-1] ^ w_dig_last[DIGIT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s   <= '0;
            r_c   <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_open[STAGES-1] && w_vin[STAGES-1]) begin
            r_s   <= w_s_next;
            r_c   <= w_dig_last[DIGIT];
            r_ovf <= w_ovf_next;
        end
    end

    assign s   = r_s;
    assign c   = r_c;
    assign ovf = r_ovf;

endmodule
`default_nettype wire
